// File: rtl/truth_table_checker_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_checker_pkg
//
// Purpose : Shared definitions for the truth-table checker: FSM state
//           encodings, the reference truth table of the team's 4-input
//           NAND/AND/NOR network, and settle-time limits.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package truth_table_checker_pkg;

    // Sweep controller states. Encodings are fixed so that state values seen
    // in a waveform match the documentation of the checker.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Truth table of y = ~c & ~(a & d) with vector bit 3 = a, bit 0 = d.
    // Bit i is the required output for input vector i.
    localparam logic [15:0] EXPECTED_NAND4 = 16'h1133;

    // Largest supported hold time per vector, and the counter width that
    // covers it.
    localparam int SETTLE_MAX = 255;
    localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);

endpackage : truth_table_checker_pkg

// File: rtl/truth_table_checker_if.sv
// -----------------------------------------------------------------------------
// truth_table_checker_if
//
// Purpose : Bundles the checker's control, DUT-facing and result signals.
//           The checker connects through the slave modport; whatever drives
//           start and returns the DUT output uses the master modport.
// Signals :
//   start        master->slave  begin a sweep (sampled only while idle)
//   dut_y        master->slave  output bit of the network under test
//   vec_out      slave->master  input vector currently applied to the network
//   busy         slave->master  sweep in progress
//   done         slave->master  one-cycle pulse at sweep completion
//   pass         slave->master  captured table equals the expected table
//   tt_out       slave->master  captured truth table, bit i = y for vector i
//   mismatch_cnt slave->master  number of differing table bits
// N_IN must match the N_IN of the checker the interface is connected to.
// -----------------------------------------------------------------------------
interface truth_table_checker_if #(
    parameter int N_IN = 4
);
    logic                 start;
    logic                 dut_y;
    logic [N_IN-1:0]      vec_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2**N_IN-1:0]   tt_out;
    logic [N_IN:0]        mismatch_cnt;

    modport master (
        output start,
        output dut_y,
        input  vec_out,
        input  busy,
        input  done,
        input  pass,
        input  tt_out,
        input  mismatch_cnt
    );

    modport slave (
        input  start,
        input  dut_y,
        output vec_out,
        output busy,
        output done,
        output pass,
        output tt_out,
        output mismatch_cnt
    );
endinterface : truth_table_checker_if

// File: rtl/truth_table_checker_settle_timer.sv
// -----------------------------------------------------------------------------
// truth_table_checker_settle_timer
//
// Purpose : Counts the cycles a vector has been held. Counts while enabled,
//           wraps to zero on the terminal count, and flags that terminal
//           count combinationally so the owner can act on the same edge the
//           counter wraps.
// Ports   :
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_clear  in   synchronous clear (highest priority after reset)
//   i_en     in   count enable
//   o_tc     out  counter is at SETTLE-1
// SETTLE must lie in 1..SETTLE_MAX.
// -----------------------------------------------------------------------------
module truth_table_checker_settle_timer
    import truth_table_checker_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);
    localparam logic [SETTLE_W-1:0] TC_VAL = SETTLE_W'(SETTLE - 1);

    logic [SETTLE_W-1:0] r_count;

    // With SETTLE = 1 the terminal value is zero, so every enabled cycle is
    // a terminal cycle and the counter never leaves zero.
    assign o_tc = (r_count == TC_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            if (o_tc) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule : truth_table_checker_settle_timer

// File: rtl/truth_table_checker.sv
// -----------------------------------------------------------------------------
// truth_table_checker
//
// Purpose : Exhaustive response checker for a single-output combinational
//           network. On start it drives every N_IN-bit vector in ascending
//           order, holds each for SETTLE cycles, samples the network output
//           on the last hold cycle, builds the truth table and compares it
//           against EXPECTED.
// Ports   :
//   clk    in     clock, all state changes on the rising edge
//   rst_n  in     asynchronous active-low reset
//   bus    slave  start/dut_y in; vec_out, busy, done, pass, tt_out,
//                 mismatch_cnt out (see truth_table_checker_if)
// Parameters:
//   N_IN      number of network inputs (vec_out[N_IN-1] = input a)
//   SETTLE    hold cycles per vector, 1..SETTLE_MAX
//   EXPECTED  required truth table, bit i = y for vector i
// dut_y is assumed synchronous to clk and settled within SETTLE cycles;
// there is no synchronizer on it.
// -----------------------------------------------------------------------------
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int                 N_IN     = 4,
    parameter int                 SETTLE   = 2,
    parameter logic [2**N_IN-1:0] EXPECTED = EXPECTED_NAND4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_checker_if.slave  bus
);
    localparam int              N_VEC    = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    state_t             r_state;
    logic [N_IN-1:0]    r_vec;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [N_VEC-1:0]   r_tt;
    logic [N_IN:0]      r_mm;

    logic               w_tc;
    logic               w_timer_clear;
    logic               w_timer_en;
    logic               w_miss;
    logic [N_IN:0]      w_mm_next;

    // ------------------------------------------------------------------
    // Hold-time counter
    // ------------------------------------------------------------------
    assign w_timer_clear = (r_state == ST_IDLE) && bus.start;
    assign w_timer_en    = (r_state == ST_HOLD);

    truth_table_checker_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_timer_clear),
        .i_en    (w_timer_en),
        .o_tc    (w_tc)
    );

    // Mismatch count including the sample taken this cycle. Used both as the
    // next count and for the pass decision on the final sample, so that the
    // last vector is part of the verdict.
    assign w_miss    = bus.dut_y ^ EXPECTED[r_vec];
    assign w_mm_next = r_mm + (N_IN + 1)'(w_miss);

    // ------------------------------------------------------------------
    // Sweep FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_tt    <= '0;
            r_mm    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= ST_HOLD;
                        r_vec   <= '0;
                        r_tt    <= '0;
                        r_mm    <= '0;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (w_tc) begin
                        r_tt[r_vec] <= bus.dut_y;
                        r_mm        <= w_mm_next;
                        // Terminal vector is detected before incrementing,
                        // so the vector counter never wraps and vec_out
                        // stays at all-ones until the next sweep.
                        if (r_vec == LAST_VEC) begin
                            r_state <= ST_FINISH;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_mm_next == '0);
                        end else begin
                            r_vec <= r_vec + 1'b1;
                        end
                    end
                end

                ST_FINISH: begin
                    // start is ignored here; a held start is picked up on
                    // the following IDLE cycle.
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vec_out      = r_vec;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.pass         = r_pass;
    assign bus.tt_out       = r_tt;
    assign bus.mismatch_cnt = r_mm;

endmodule : truth_table_checker

// File: tb/tb_truth_table_checker.sv
// -----------------------------------------------------------------------------
// tb_truth_table_checker
//
// Directed bench for truth_table_checker. dut0 uses SETTLE=2 and drives a
// network whose output is selected by 'mode' (correct, stuck-at-0, inverted);
// dut1 uses SETTLE=1 with the correct network. Edges are numbered with the
// start-accepting edge as edge 1.
// -----------------------------------------------------------------------------
module tb_truth_table_checker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    truth_table_checker_if #(.N_IN(4)) if0 ();
    truth_table_checker_if #(.N_IN(4)) if1 ();

    truth_table_checker #(
        .N_IN     (4),
        .SETTLE   (2),
        .EXPECTED (16'h1133)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    truth_table_checker #(
        .N_IN     (4),
        .SETTLE   (1),
        .EXPECTED (16'h1133)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    // Gate-level model of the 4-input network: y = NOR(c, AND(a, d)).
    function automatic logic net_y(input logic [3:0] v);
        logic a, c, d, and_ad;
        a      = v[3];
        c      = v[1];
        d      = v[0];
        and_ad = a & d;
        return ~(c | and_ad);
    endfunction

    int mode = 0; // 0: correct, 1: stuck at 0, 2: inverted

    assign if0.dut_y = (mode == 0) ? net_y(if0.vec_out) :
                       (mode == 1) ? 1'b0 : ~net_y(if0.vec_out);
    assign if1.dut_y = net_y(if1.vec_out);

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic b);
        if (sel != 0) if1.start = b;
        else          if0.start = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one sweep, checking vec_out after every edge, and returns the edge
    // number on which done was first seen (-1 if it never came).
    task automatic sweep(input int sel, input int settle_n, input bit extra,
                         output int done_edge);
        int          e;
        int          exp_v;
        logic [3:0]  v;
        logic        d;
        logic        b;
        done_edge = -1;
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        e = 1;
        b = (sel != 0) ? if1.busy : if0.busy;
        check("busy_after_start", {31'd0, b}, 32'd1);
        while (done_edge < 0 && e < 80) begin
            v     = (sel != 0) ? if1.vec_out : if0.vec_out;
            d     = (sel != 0) ? if1.done : if0.done;
            exp_v = (e - 1) / settle_n;
            if (exp_v > 15) exp_v = 15;
            check($sformatf("vec_edge%0d", e), {28'd0, v}, exp_v);
            if (d) begin
                done_edge = e;
            end else begin
                set_start(sel, extra && (e + 1 == 10 || e + 1 == 33));
                tick();
                e++;
            end
        end
        set_start(sel, 1'b0);
        $display("sweep sel=%0d settle=%0d mode=%0d done_edge=%0d", sel, settle_n, mode, done_edge);
    endtask

    task automatic check_result(input string tag, input logic [15:0] tt,
                                input logic [4:0] mm, input logic p);
        check({tag, "_tt"},   {16'd0, if0.tt_out},       {16'd0, tt});
        check({tag, "_mm"},   {27'd0, if0.mismatch_cnt}, {27'd0, mm});
        check({tag, "_pass"}, {31'd0, if0.pass},         {31'd0, p});
        check({tag, "_busy"}, {31'd0, if0.busy},         32'd0);
    endtask

    int de;

    initial begin
        if0.start = 1'b0;
        if1.start = 1'b0;

        // Reset values
        #2;
        check("rst_vec",  {28'd0, if0.vec_out},      32'd0);
        check("rst_busy", {31'd0, if0.busy},         32'd0);
        check("rst_done", {31'd0, if0.done},         32'd0);
        check("rst_pass", {31'd0, if0.pass},         32'd0);
        check("rst_tt",   {16'd0, if0.tt_out},       32'd0);
        check("rst_mm",   {27'd0, if0.mismatch_cnt}, 32'd0);
        #10;
        rst_n = 1'b1;

        // 1: correct network
        mode = 0;
        sweep(0, 2, 1'b0, de);
        check("t1_done_edge", de, 33);
        check_result("t1", 16'h1133, 5'd0, 1'b1);
        tick();
        check("t1_done_pulse", {31'd0, if0.done}, 32'd0);
        check("t1_vec_hold", {28'd0, if0.vec_out}, 32'd15);

        // 2: stuck-at-0 output
        mode = 1;
        sweep(0, 2, 1'b0, de);
        check("t2_done_edge", de, 33);
        check_result("t2", 16'h0000, 5'd6, 1'b0);
        tick();

        // 3: inverted output, every bit wrong
        mode = 2;
        sweep(0, 2, 1'b0, de);
        check("t3_done_edge", de, 33);
        check_result("t3", 16'hEECC, 5'd16, 1'b0);
        tick();

        // 4: extra starts at edges 10 and 33, and one during FINISH
        mode = 0;
        sweep(0, 2, 1'b1, de);
        check("t4_done_edge", de, 33);
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        check("t4_finish_done", {31'd0, if0.done}, 32'd0);
        check("t4_finish_busy", {31'd0, if0.busy}, 32'd0);
        tick();
        check("t4_idle_done", {31'd0, if0.done}, 32'd0);
        check("t4_idle_busy", {31'd0, if0.busy}, 32'd0);
        check_result("t4", 16'h1133, 5'd0, 1'b1);

        // 5: asynchronous reset in the middle of a sweep
        mode = 2;
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        repeat (14) tick();
        check("t5_pre_vec", {28'd0, if0.vec_out},      32'd7);
        check("t5_pre_tt",  {16'd0, if0.tt_out},       32'h004C);
        check("t5_pre_mm",  {27'd0, if0.mismatch_cnt}, 32'd7);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_vec",  {28'd0, if0.vec_out},      32'd0);
        check("t5_rst_busy", {31'd0, if0.busy},         32'd0);
        check("t5_rst_tt",   {16'd0, if0.tt_out},       32'd0);
        check("t5_rst_mm",   {27'd0, if0.mismatch_cnt}, 32'd0);
        #2;
        rst_n = 1'b1;
        mode  = 0;
        sweep(0, 2, 1'b0, de);
        check("t5_done_edge", de, 33);
        check_result("t5", 16'h1133, 5'd0, 1'b1);

        // 6: SETTLE=1 instance
        sweep(1, 1, 1'b0, de);
        check("t6_done_edge", de, 17);
        check("t6_tt",   {16'd0, if1.tt_out},       32'h1133);
        check("t6_mm",   {27'd0, if1.mismatch_cnt}, 32'd0);
        check("t6_pass", {31'd0, if1.pass},         32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_truth_table_checker
